// File: rtl/ex_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_unit
// Purpose  : Execute stage of the 5-stage LoongArch pipeline. Latches the
//            decode-stage bus, computes the ALU result, optionally runs an
//            iterative restoring divider, issues the data SRAM request and
//            hands the 71-bit result bus to the memory stage under the
//            valid/allow-in handshake.
// Ports    : clk, reset (async, active-high)
//            ID_to_EX_Valid / ID_to_EX_Bus / ID_div_en - decode-stage input
//            EX_Allow_in                               - back-pressure to ID
//            ME_Allow_in                               - back-pressure from ME
//            EX_to_ME_Valid / EX_to_ME_Bus             - result to ME
//            data_sram_en/we/addr/wdata                - data SRAM request
//            EX_dest                                   - dest for hazard check
// Macro    : EX_DIV_EN - when defined, the DIV/MOD divider FSM and datapath
//            are built; when undefined, DIV/MOD pass in one cycle carrying
//            their ALU result.
// Revision : 1.0 - initial release
// ============================================================================
module ex_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ID_to_EX_Valid,
    input  logic         ME_Allow_in,
    output logic         EX_Allow_in,
    input  logic [149:0] ID_to_EX_Bus,
    input  logic         ID_div_en,
    output logic         EX_to_ME_Valid,
    output logic [70:0]  EX_to_ME_Bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [4:0]   EX_dest
);

    logic         r_valid;
    logic [149:0] r_bus;
    logic         r_div_en;

    logic [31:0]  w_pc;
    logic [11:0]  w_alu_op;
    logic [31:0]  w_src1;
    logic [31:0]  w_src2;
    logic [31:0]  w_rkd;
    logic         w_mem_we;
    logic         w_res_from_mem;
    logic         w_gr_we;
    logic [4:0]   w_dest;
    logic         w_ready_go;
    logic [31:0]  w_alu_result;
    logic [31:0]  w_result;
    logic [31:0]  w_sra;

    assign w_pc           = r_bus[149:118];
    assign w_alu_op       = r_bus[117:106];
    assign w_src1         = r_bus[105:74];
    assign w_src2         = r_bus[73:42];
    assign w_rkd          = r_bus[41:10];
    assign w_mem_we       = r_bus[9];
    assign w_res_from_mem = r_bus[8];
    assign w_gr_we        = r_bus[7];
    assign w_dest         = r_bus[6:2];

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_bus    <= '0;
            r_div_en <= 1'b0;
        end else begin
            if (EX_Allow_in) begin
                r_valid <= ID_to_EX_Valid;
            end
            if (EX_Allow_in && ID_to_EX_Valid) begin
                r_bus    <= ID_to_EX_Bus;
                r_div_en <= ID_div_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU: one-hot opcode, AND-OR mux so an all-zero opcode yields 0
    // ------------------------------------------------------------------
    assign w_sra = $signed(w_src1) >>> w_src2[4:0];

    assign w_alu_result =
          ({32{w_alu_op[0]}}  & (w_src1 + w_src2))
        | ({32{w_alu_op[1]}}  & (w_src1 - w_src2))
        | ({32{w_alu_op[2]}}  & {31'b0, $signed(w_src1) < $signed(w_src2)})
        | ({32{w_alu_op[3]}}  & {31'b0, w_src1 < w_src2})
        | ({32{w_alu_op[4]}}  & (w_src1 & w_src2))
        | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2))
        | ({32{w_alu_op[6]}}  & (w_src1 | w_src2))
        | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2))
        | ({32{w_alu_op[8]}}  & (w_src1 << w_src2[4:0]))
        | ({32{w_alu_op[9]}}  & (w_src1 >> w_src2[4:0]))
        | ({32{w_alu_op[10]}} & w_sra)
        | ({32{w_alu_op[11]}} & w_src2);

`ifdef EX_DIV_EN
    // ------------------------------------------------------------------
    // Iterative restoring divider operating on magnitudes; signs are
    // re-applied on the way out.
    // ------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(DIV_ITERS) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t         r_div_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_quo;       // dividend shifts out, quotient shifts in
    logic [31:0]        r_rem;
    logic [31:0]        r_divisor;
    logic               r_quo_neg;
    logic               r_rem_neg;
    logic               r_div_zero;

    logic        w_div_signed;
    logic        w_div_rem;
    logic        w_src1_neg;
    logic        w_src2_neg;
    logic [32:0] w_rem_shift;
    logic        w_sub_ok;
    logic [31:0] w_rem_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quotient;
    logic [31:0] w_remainder;

    assign w_div_signed = r_bus[1];
    assign w_div_rem    = r_bus[0];
    assign w_src1_neg   = w_div_signed & w_src1[31];
    assign w_src2_neg   = w_div_signed & w_src2[31];

    assign w_rem_shift = {r_rem, r_quo[31]};
    assign w_sub_ok    = w_rem_shift >= {1'b0, r_divisor};
    // The true difference is below the divisor, so 32 bits suffice
    assign w_rem_diff  = w_rem_shift[31:0] - r_divisor;
    assign w_rem_next  = w_sub_ok ? w_rem_diff : w_rem_shift[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_state <= S_IDLE;
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_quo_neg   <= 1'b0;
            r_rem_neg   <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_div_state)
                S_IDLE: begin
                    if (r_valid && r_div_en) begin
                        r_quo       <= w_src1_neg ? -w_src1 : w_src1;
                        r_divisor   <= w_src2_neg ? -w_src2 : w_src2;
                        r_rem       <= '0;
                        r_quo_neg   <= w_src1_neg ^ w_src2_neg;
                        r_rem_neg   <= w_src1_neg;
                        r_div_zero  <= (w_src2 == 32'd0);
                        r_cnt       <= '0;
                        r_div_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[30:0], w_sub_ok};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_div_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_valid && ME_Allow_in) begin
                        r_div_state <= S_IDLE;
                    end
                end
                default: r_div_state <= S_IDLE;
            endcase
        end
    end

    // Divide-by-zero forces an all-ones quotient regardless of sign; the
    // remainder then equals |src1| with src1's sign, i.e. src1 itself.
    assign w_quotient  = r_div_zero ? 32'hFFFF_FFFF : (r_quo_neg ? -r_quo : r_quo);
    assign w_remainder = r_rem_neg ? -r_rem : r_rem;

    assign w_ready_go = !r_div_en || (r_div_state == S_DONE);
    assign w_result   = r_div_en ? (w_div_rem ? w_remainder : w_quotient) : w_alu_result;
`else
    logic w_unused_div;

    assign w_ready_go   = 1'b1;
    assign w_result     = w_alu_result;
    assign w_unused_div = &{1'b0, r_div_en, r_bus[1:0]};
`endif

    // ------------------------------------------------------------------
    // Handshake and outputs
    // ------------------------------------------------------------------
    assign EX_Allow_in     = !r_valid || (w_ready_go && ME_Allow_in);
    assign EX_to_ME_Valid  = r_valid && w_ready_go;
    assign EX_to_ME_Bus    = {w_pc, w_result, w_res_from_mem, w_gr_we, w_dest};

    // Request only on the handoff cycle so a stalled access is issued once
    assign data_sram_en    = r_valid && (w_mem_we || w_res_from_mem)
                             && w_ready_go && ME_Allow_in;
    assign data_sram_we    = {4{w_mem_we && data_sram_en}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rkd;

    assign EX_dest         = (r_valid && w_gr_we) ? w_dest : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_ex_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_unit
// Purpose  : Self-checking bench for ex_unit: table-driven ALU vectors,
//            hand-written handshake/divider/reset sequences and a randomized
//            phase scored against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_unit;

`ifdef EX_DIV_EN
    localparam bit c_DIV = 1'b1;
`else
    localparam bit c_DIV = 1'b0;
`endif
    localparam int c_DIV_LAT = c_DIV ? 34 : 1;
    localparam int c_N_RAND  = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         ID_to_EX_Valid;
    logic         ME_Allow_in;
    logic         EX_Allow_in;
    logic [149:0] ID_to_EX_Bus;
    logic         ID_div_en;
    logic         EX_to_ME_Valid;
    logic [70:0]  EX_to_ME_Bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [4:0]   EX_dest;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_unit #(.DIV_ITERS(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_to_EX_Valid (ID_to_EX_Valid),
        .ME_Allow_in    (ME_Allow_in),
        .EX_Allow_in    (EX_Allow_in),
        .ID_to_EX_Bus   (ID_to_EX_Bus),
        .ID_div_en      (ID_div_en),
        .EX_to_ME_Valid (EX_to_ME_Valid),
        .EX_to_ME_Bus   (EX_to_ME_Bus),
        .data_sram_en   (data_sram_en),
        .data_sram_we   (data_sram_we),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .EX_dest        (EX_dest)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [70:0] bus;
        logic        mem;
        logic        mwe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        gwe;
        logic [4:0]  dst;
    } exp_t;

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [149:0] mk_bus(input logic [31:0] pc, input int op,
                                            input logic [31:0] s1, input logic [31:0] s2,
                                            input logic [31:0] rkd, input logic mwe,
                                            input logic rfm, input logic gwe,
                                            input logic [4:0] dst, input logic dsg,
                                            input logic drm);
        logic [11:0] oh;
        oh = (op < 12) ? (12'b1 << op) : 12'b0;
        return {pc, oh, s1, s2, rkd, mwe, rfm, gwe, dst, dsg, drm};
    endfunction

    // Reference ALU: op index 0..11 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << sh;
            9:  return a >> sh;
            10: return $signed(a) >>> sh;
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference divide using the language's own truncating division
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic rem);
        int sa;
        int sb;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b,
                                               input logic is_div, input logic sgn, input logic rem);
        if (c_DIV && is_div) return ref_div(a, b, sgn, rem);
        return ref_alu(op, a, b);
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction with ME ready and wait for it to reach ME
    task automatic issue(input string name, input logic [149:0] bus, input logic de,
                         input logic [31:0] exp_res, input int exp_lat);
        int   n;
        logic seen;
        logic stall_ok;
        @(negedge clk);
        ID_to_EX_Valid = 1'b1;
        ID_to_EX_Bus   = bus;
        ID_div_en      = de;
        ME_Allow_in    = 1'b1;
        @(posedge clk);
        #1;
        ID_to_EX_Valid = 1'b0;
        n = 0;
        seen = 1'b0;
        stall_ok = 1'b1;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (EX_to_ME_Valid) seen = 1'b1;
            else if (EX_Allow_in) stall_ok = 1'b0;
        end
        check({name, " latency"}, 71'(n), 71'(exp_lat));
        check({name, " allow_in low while busy"}, 71'(stall_ok), 71'(1));
        check({name, " result"}, 71'(EX_to_ME_Bus[38:7]), 71'(exp_res));
        check({name, " pc"}, 71'(EX_to_ME_Bus[70:39]), 71'(bus[149:118]));
        @(posedge clk);
    endtask

    vec_t vt[13];
    exp_t q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        logic any_valid;
        int   issued;
        logic have_pend;
        exp_t pend_exp;
        logic [149:0] pend_bus;
        logic pend_div;
        exp_t e;

        reset          = 1'b1;
        ID_to_EX_Valid = 1'b0;
        ID_to_EX_Bus   = '0;
        ID_div_en      = 1'b0;
        ME_Allow_in    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset ex_to_me_valid", 71'(EX_to_ME_Valid), 71'(0));
        check("reset sram_en", 71'(data_sram_en), 71'(0));
        check("reset allow_in", 71'(EX_Allow_in), 71'(1));
        check("reset ex_dest", 71'(EX_dest), 71'(0));

        // ---------------- ALU vector table ----------------
        vt[0]  = '{4'd0,  32'd5,          32'd7,          32'd12};
        vt[1]  = '{4'd1,  32'd5,          32'd7,          32'hFFFF_FFFE};
        vt[2]  = '{4'd2,  32'hFFFF_FFFF,  32'd1,          32'd1};
        vt[3]  = '{4'd3,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vt[4]  = '{4'd4,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
        vt[5]  = '{4'd5,  32'd0,          32'd0,          32'hFFFF_FFFF};
        vt[6]  = '{4'd6,  32'h0F0F_0000,  32'h0000_F0F0,  32'h0F0F_F0F0};
        vt[7]  = '{4'd7,  32'hAAAA_AAAA,  32'hFFFF_FFFF,  32'h5555_5555};
        vt[8]  = '{4'd8,  32'd1,          32'h21,         32'd2};
        vt[9]  = '{4'd9,  32'h8000_0000,  32'd31,         32'd1};
        vt[10] = '{4'd10, 32'h8000_0000,  32'd4,          32'hF800_0000};
        vt[11] = '{4'd11, 32'd99,         32'h1234_5000,  32'h1234_5000};
        vt[12] = '{4'd12, 32'd3,          32'd4,          32'd0};
        for (int i = 0; i < 13; i++) begin
            issue($sformatf("alu_vec[%0d]", i),
                  mk_bus(32'h1000 + 32'(4 * i), int'(vt[i].op), vt[i].a, vt[i].b, 32'd0,
                         1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0),
                  1'b0, vt[i].exp, 1);
        end

        // ---------------- back-to-back adds ----------------
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ME_Allow_in = 1'b1;
            #1;
            if (i > 0) begin
                check("b2b valid", 71'(EX_to_ME_Valid), 71'(1));
                check("b2b result", 71'(EX_to_ME_Bus[38:7]), 71'(12));
                check("b2b pc", 71'(EX_to_ME_Bus[70:39]), 71'(32'h100 + 32'(4 * (i - 1))));
                check("b2b dest", 71'(EX_to_ME_Bus[4:0]), 71'(i));
            end
            if (i < 4) begin
                ID_to_EX_Valid = 1'b1;
                ID_div_en      = 1'b0;
                ID_to_EX_Bus   = mk_bus(32'h100 + 32'(4 * i), 0, 32'd5, 32'd7, 32'd0,
                                        1'b0, 1'b0, 1'b1, 5'(i + 1), 1'b0, 1'b0);
            end else begin
                ID_to_EX_Valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b drained", 71'(EX_to_ME_Valid), 71'(0));

        // ---------------- store with ME stall ----------------
        @(negedge clk);
        ID_to_EX_Valid = 1'b1;
        ID_div_en      = 1'b0;
        ID_to_EX_Bus   = mk_bus(32'h200, 0, 32'h800, 32'h800, 32'hDEAD_BEEF,
                                1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        ME_Allow_in    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ID_to_EX_Valid = 1'b0;
            #1;
            check("store stall sram_en", 71'(data_sram_en), 71'(0));
        end
        ME_Allow_in = 1'b1;
        #1;
        check("store sram_en", 71'(data_sram_en), 71'(1));
        check("store sram_we", 71'(data_sram_we), 71'(4'hF));
        check("store sram_addr", 71'(data_sram_addr), 71'(32'h1000));
        check("store sram_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
        @(negedge clk);
        check("store single request", 71'(data_sram_en), 71'(0));

        // ---------------- asynchronous reset between edges ----------------
        @(negedge clk);
        ID_to_EX_Valid = 1'b1;
        ID_to_EX_Bus   = mk_bus(32'h300, 0, 32'h10, 32'h20, 32'd0,
                                1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        ME_Allow_in    = 1'b0;
        @(negedge clk);
        ID_to_EX_Valid = 1'b0;
        ME_Allow_in    = 1'b1;
        #1;
        check("pre-reset sram_en", 71'(data_sram_en), 71'(1));
        check("pre-reset ex_dest", 71'(EX_dest), 71'(9));
        #2;
        reset = 1'b1;
        #1;
        check("async reset ex_to_me_valid", 71'(EX_to_ME_Valid), 71'(0));
        check("async reset sram_en", 71'(data_sram_en), 71'(0));
        check("async reset ex_dest", 71'(EX_dest), 71'(0));
        check("async reset allow_in", 71'(EX_Allow_in), 71'(1));
        @(negedge clk);
        reset = 1'b0;

        // ---------------- divider ----------------
        issue("sdiv -7/2", mk_bus(32'h400, 0, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0),
              1'b1, c_DIV ? 32'hFFFF_FFFD : 32'hFFFF_FFFB, c_DIV_LAT);
        issue("smod -7%2", mk_bus(32'h404, 0, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1),
              1'b1, c_DIV ? 32'hFFFF_FFFF : 32'hFFFF_FFFB, c_DIV_LAT);
        issue("sdiv ovf", mk_bus(32'h408, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0),
              1'b1, c_DIV ? 32'h8000_0000 : 32'h7FFF_FFFF, c_DIV_LAT);
        issue("smod -5%0", mk_bus(32'h40C, 0, 32'hFFFF_FFFB, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1),
              1'b1, 32'hFFFF_FFFB, c_DIV_LAT);
        issue("sdiv -5/0", mk_bus(32'h410, 0, 32'hFFFF_FFFB, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0),
              1'b1, c_DIV ? 32'hFFFF_FFFF : 32'hFFFF_FFFB, c_DIV_LAT);

        // udiv 100/0 followed back-to-back by umod 0xFFFFFFFF % 10
        @(negedge clk);
        ID_to_EX_Valid = 1'b1;
        ID_div_en      = 1'b1;
        ID_to_EX_Bus   = mk_bus(32'h500, 0, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
        ME_Allow_in    = 1'b1;
        @(posedge clk);
        #1;
        ID_to_EX_Bus   = mk_bus(32'h504, 0, 32'hFFFF_FFFF, 32'd10, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (EX_to_ME_Valid) seen = 1'b1;
        end
        check("udiv 100/0 latency", 71'(n), 71'(c_DIV_LAT));
        check("udiv 100/0 result", 71'(EX_to_ME_Bus[38:7]), 71'(c_DIV ? 32'hFFFF_FFFF : 32'd100));
        check("udiv handoff allow_in", 71'(EX_Allow_in), 71'(1));
        @(posedge clk);
        #1;
        ID_to_EX_Valid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (EX_to_ME_Valid) seen = 1'b1;
        end
        check("umod b2b latency", 71'(n), 71'(c_DIV_LAT));
        check("umod b2b result", 71'(EX_to_ME_Bus[38:7]), 71'(c_DIV ? 32'd5 : 32'd9));
        check("umod b2b pc", 71'(EX_to_ME_Bus[70:39]), 71'(32'h504));
        @(posedge clk);

        // reset pulsed while a divide is in progress
        @(negedge clk);
        ID_to_EX_Valid = 1'b1;
        ID_div_en      = 1'b1;
        ID_to_EX_Bus   = mk_bus(32'h600, 0, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        ID_to_EX_Valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid-div reset valid", 71'(EX_to_ME_Valid), 71'(0));
        check("mid-div reset allow_in", 71'(EX_Allow_in), 71'(1));
        @(negedge clk);
        reset = 1'b0;
        any_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (EX_to_ME_Valid) any_valid = 1'b1;
        end
        check("mid-div reset nothing forwarded", 71'(any_valid), 71'(0));
        issue("post-reset add", mk_bus(32'h700, 0, 32'd9, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0),
              1'b0, 32'd12, 1);
        issue("div 9/3", mk_bus(32'h704, 0, 32'd9, 32'd3, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0),
              1'b1, c_DIV ? 32'd3 : 32'd12, c_DIV_LAT);

        // ---------------- randomized phase with reference model ----------------
        issued    = 0;
        have_pend = 1'b0;
        pend_exp  = '0;
        pend_bus  = '0;
        pend_div  = 1'b0;
        for (int cyc = 0; cyc < 20000 && (issued < c_N_RAND || have_pend || q.size() != 0); cyc++) begin
            @(negedge clk);
            if (!have_pend && issued < c_N_RAND && $urandom_range(0, 3) != 0) begin
                int          kind;
                int          op;
                logic [31:0] a, b, rkd, pc;
                logic [4:0]  dst;
                logic        mwe, rfm, gwe, dsg, drm, isdiv;
                kind  = int'($urandom_range(0, 7));
                op    = int'($urandom_range(0, 12));
                a     = rnd32();
                b     = rnd32();
                rkd   = $urandom;
                pc    = $urandom;
                dst   = 5'($urandom_range(0, 31));
                mwe   = (kind == 2);
                rfm   = (kind == 1);
                gwe   = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                isdiv = (kind == 0);
                dsg   = 1'($urandom_range(0, 1));
                drm   = 1'($urandom_range(0, 1));
                if (mwe || rfm) op = 0;
                pend_bus       = mk_bus(pc, op, a, b, rkd, mwe, rfm, gwe, dst, dsg, drm);
                pend_div       = isdiv;
                pend_exp.bus   = {pc, ref_result(op, a, b, isdiv, dsg, drm), rfm, gwe, dst};
                pend_exp.mem   = mwe | rfm;
                pend_exp.mwe   = mwe;
                pend_exp.addr  = ref_alu(op, a, b);
                pend_exp.wdata = rkd;
                pend_exp.gwe   = gwe;
                pend_exp.dst   = dst;
                have_pend      = 1'b1;
                issued++;
            end
            ID_to_EX_Valid = have_pend;
            ID_to_EX_Bus   = pend_bus;
            ID_div_en      = pend_div;
            ME_Allow_in    = ($urandom_range(0, 3) != 0);
            #1;
            if (q.size() != 0) check("rand ex_dest", 71'(EX_dest), 71'((q[0].gwe) ? q[0].dst : 5'd0));
            else               check("rand ex_dest idle", 71'(EX_dest), 71'(0));
            if (EX_to_ME_Valid && ME_Allow_in) begin
                if (q.size() == 0) begin
                    check("rand unexpected handoff", 71'(1), 71'(0));
                end else begin
                    e = q.pop_front();
                    check("rand bus", EX_to_ME_Bus, e.bus);
                    check("rand sram_en", 71'(data_sram_en), 71'(e.mem));
                    check("rand sram_we", 71'(data_sram_we), 71'({4{e.mwe}}));
                    if (e.mem) begin
                        check("rand sram_addr", 71'(data_sram_addr), 71'(e.addr));
                        check("rand sram_wdata", 71'(data_sram_wdata), 71'(e.wdata));
                    end
                end
            end else begin
                check("rand sram_en idle", 71'(data_sram_en), 71'(0));
            end
            if (EX_Allow_in && have_pend) begin
                q.push_back(pend_exp);
                have_pend = 1'b0;
            end
        end
        @(negedge clk);
        ID_to_EX_Valid = 1'b0;
        check("rand all issued", 71'(issued), 71'(c_N_RAND));
        check("rand all retired", 71'(q.size()), 71'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Execute stage of the 5-stage LoongArch pipeline; sits between the decode stage and the memory stage.
- Latches the decode-stage bus and computes the ALU result.
- Runs a multi-cycle iterative divider and issues the data SRAM request.
- Drives the 71-bit EX_to_ME_Bus consumed by the memory stage under the valid/allow-in handshake.

Parameters:
- DIV_ITERS, 32, number of BUSY-state divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ID_to_EX_Valid  in  1  upstream instruction valid
- ME_Allow_in  in  1  memory stage can accept
- EX_Allow_in  out  1  this stage can accept
- ID_to_EX_Bus  in  150  {pc[149:118], alu_op[117:106], src1[105:74], src2[73:42], rkd_value[41:10], mem_we[9], res_from_mem[8], gr_we[7], dest[6:2], div_signed[1], div_rem[0]}; div_en is carried separately below
- ID_div_en  in  1  instruction is DIV/MOD
- EX_to_ME_Valid  out  1  valid toward memory stage
- EX_to_ME_Bus  out  71  {pc[70:39], result[38:7], res_from_mem[6], gr_we[5], dest[4:0]}
- data_sram_en  out  1  SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  word address (= alu result)
- data_sram_wdata  out  32  store data (= rkd_value)
- EX_dest  out  5  dest for hazard detection; 0 when no valid GPR write

Behaviour:
- Handshake:
  - EX_ReadyGO = !div_en || div_state==DONE.
  - EX_Allow_in = !EX_Valid || (EX_ReadyGO && ME_Allow_in).
  - EX_to_ME_Valid = EX_Valid && EX_ReadyGO.
- Registers:
  - EX_Valid loads ID_to_EX_Valid when EX_Allow_in.
  - Payload registers (bus fields, div_en) load when EX_Allow_in && ID_to_EX_Valid; otherwise they hold.
- Reset (async): EX_Valid=0, div_state=IDLE, iteration counter=0, quotient/remainder registers=0.
  - Hence after reset: EX_to_ME_Valid=0, data_sram_en=0, EX_Allow_in=1, EX_dest=0.
- ALU: alu_op is one-hot, bit order {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui} = bits 0..11.
  - Shifts use src2[4:0].
  - lui result = src2.
  - slt/sltu result is zero-extended 1 bit.
  - All-zero alu_op gives result 0.
- Result mux: div_en ? (div_rem ? remainder : quotient) : alu_result.
- SRAM:
  - data_sram_en = EX_Valid && (mem_we || res_from_mem) && EX_to_ME handoff (EX_ReadyGO && ME_Allow_in). Exactly one request per instruction.
  - data_sram_we = {4{mem_we && data_sram_en}}; word accesses only.
- EX_dest = (EX_Valid && gr_we) ? dest : 0.
- Divider FSM (states IDLE, BUSY, DONE):
  - IDLE -> BUSY when EX_Valid && div_en. Latch |src1| and |src2| (signed case) or raw values, plus the result signs; counter=0.
  - BUSY: restoring shift-subtract, one bit per cycle. After DIV_ITERS iterations -> DONE.
  - DONE: ReadyGO=1; hold results until handoff (EX_Valid && ME_Allow_in), then -> IDLE.
  - Latency: a divide occupies EX for DIV_ITERS+2 cycles minimum; stalls extend DONE.
  - Signed fix-up: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient 32'hFFFFFFFF, remainder = src1 unchanged.
  - Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
- Back-to-back: at a DONE handoff the next instruction loads on the same edge; if it is also a divide, it starts from IDLE on the following cycle.
- Reset asserted mid-divide aborts immediately; no stale result is forwarded.
- Non-divide instructions never change div_state.

Optional Feature:
- Macro: EX_DIV_EN.
- Defined: divider FSM and datapath present, as above.
- Undefined:
  - No divider logic; div_en, div_signed, div_rem are ignored.
  - EX_ReadyGO is constant 1 and result = alu_result.
  - A DIV/MOD instruction passes in 1 cycle with its ALU result.

Test Plan:
- Reset asserted asynchronously between clock edges with EX_Valid=1 -> EX_to_ME_Valid and data_sram_en drop immediately, EX_dest=0, EX_Allow_in=1.
- add, src1=5, src2=7, ME_Allow_in=1 -> next cycle EX_to_ME_Bus result=12, pc/dest forwarded, one-cycle throughput over 4 back-to-back instructions.
- store, src1+src2=0x1000, rkd=0xDEADBEEF, ME_Allow_in held 0 for 3 cycles -> data_sram_en/we=0xF asserted only on the release cycle, addr=0x1000, wdata=0xDEADBEEF.
- signed div -7/2 with rem -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF (mod selects it); EX_to_ME_Valid rises exactly 34 cycles after load; EX_Allow_in=0 meanwhile.
- unsigned div 100/0 -> quotient 0xFFFFFFFF; then back-to-back unsigned mod 0xFFFFFFFF%10 -> 5, restarts cleanly from IDLE.
- Reset pulsed during BUSY on a divide -> FSM returns to IDLE and nothing is forwarded; with EX_DIV_EN undefined, div 9/3 passes in 1 cycle carrying its ALU result.
